hidden_layer_sequencer: RTL
===========================

Name: hidden_layer_sequencer

Overview:
- Control FSM that runs one hidden layer of the network, one neuron at a time, on a single shared MAC unit.
- For each neuron it clears the MAC, then streams input-vector and weight-memory addresses with a one-cycle read-latency-aligned enable.
- It then adds that neuron's bias from the hidden-bias memory, applies ReLU plus saturation, and writes the 8-bit activation to the hidden-output buffer.
- It sits between the top-level network controller (start/done) and the hidden-layer MAC, weight/bias memories and output buffer.

Parameters:
- N_IN, 30, inputs per neuron (MAC steps per neuron).
- N_NEURON, 10, hidden neurons per layer; bias indices 0..N_NEURON-1.
- ACCW, 20, MAC accumulator width (signed).
- SHIFT, 4, fractional bits removed from (acc + bias) before saturation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin layer; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done, inclusive.
- done  out  1  one-cycle pulse: all N_NEURON outputs written.
- in_addr  out  clog2(N_IN)  input-vector read address.
- w_addr  out  clog2(N_IN*N_NEURON)  weight read address = neuron*N_IN + i.
- bias_sel  out  clog2(N_NEURON)  selects current neuron's bias word.
- bias  in  8  signed bias of neuron bias_sel (combinational).
- mac_clr  out  1  synchronous clear of MAC accumulator.
- mac_en  out  1  MAC accumulates product of current memory outputs.
- mac_acc  in  ACCW  signed accumulator value (registered in MAC).
- out_we  out  1  hidden-output buffer write enable.
- out_addr  out  clog2(N_NEURON)  write address = neuron index.
- out_data  out  8  activation written.

Behaviour:
- States: IDLE, CLEAR, MAC, DRAIN, WRITE, DONE. Counters: n (neuron), i (input).
- Reset (any state, incl. mid-layer): state=IDLE, n=i=0. busy, done, mac_clr, mac_en and out_we are 0. in_addr, w_addr, bias_sel, out_addr and out_data are 0. No write may occur in the reset cycle.
- IDLE: start=1 -> CLEAR. start while busy is ignored; it is neither queued nor restarts the layer.
- CLEAR, 1 cycle: mac_clr=1, i=0, bias_sel=n -> MAC.
- MAC, N_IN cycles: in_addr=i, w_addr=n*N_IN+i, i increments each cycle. Memories have 1-cycle read latency, so mac_en is the 1-cycle-delayed issue strobe: low in the first MAC cycle, high in the remaining N_IN-1. After i=N_IN-1 -> DRAIN.
- DRAIN, 1 cycle: mac_en=1 for the last product; no new address -> WRITE.
- WRITE, 1 cycle:
  - sum = mac_acc + sign_extend(bias) << SHIFT, computed at ACCW+1 bits with no overflow.
  - r = sum >>> SHIFT.
  - out_data = 0 if r<0; 127 if r>127; else r[7:0].
  - out_we=1, out_addr=n.
  - If n=N_NEURON-1 -> DONE; else n++ -> CLEAR.
- DONE, 1 cycle: done=1, busy=1 -> IDLE, busy drops next cycle. start during DONE is ignored.
- Latency: N_IN+3 cycles per neuron. done is high exactly N_NEURON*(N_IN+3)+1 cycles after the start-sampling edge (331 at defaults).
- mac_clr, mac_en and out_we are never high in the same cycle. mac_en pulses total exactly N_IN per neuron.
- n and i never exceed N_NEURON-1 / N_IN-1; no address wrap beyond N_IN*N_NEURON-1.

Test Plan:
- Defaults, reset then start=1 for 1 cycle -> busy=1 next cycle. Exactly 10 out_we pulses, out_addr 0..9 in order, 30 mac_en per neuron. done pulse 331 cycles after start edge, then busy=0.
- MAC model = sum of w*x; weights all 1, inputs all 2, bias[k]=k, SHIFT=4 -> sum=60+16k, r=3+k, out_data[k]=3+k.
- Saturation: acc=+4000, bias=0 -> r=250, out_data=127. acc=-100, bias=-5 -> r<0, out_data=0. acc=-1 (>>> gives -1) -> out_data=0.
- Address check, neuron 3 -> w_addr sweeps 90..119 and bias_sel=3 throughout. mac_en lags the first address by 1 cycle and stays high 1 cycle past the last.
- start held high for the whole layer and during DONE -> exactly one layer run; a second run begins only on a start seen in IDLE.
- rst=1 while in MAC of neuron 4 -> next cycle all outputs 0, state IDLE. No out_we for neuron 4. A following start restarts from neuron 0 and completes in 331 cycles.

Source files
------------

// File: rtl/hidden_layer_sequencer.sv
// Hidden-layer sequencer: steps one neuron at a time through a shared MAC.
// For each neuron it clears the MAC, streams input/weight addresses, then
// adds the bias, applies ReLU with saturation and writes the 8-bit activation.
module hidden_layer_sequencer #(
    parameter int unsigned N_IN     = 30,
    parameter int unsigned N_NEURON = 10,
    parameter int unsigned ACCW     = 20,
    parameter int unsigned SHIFT    = 4,
    localparam int unsigned IN_AW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned W_AW    = (N_IN * N_NEURON > 1) ? $clog2(N_IN * N_NEURON) : 1,
    localparam int unsigned N_AW    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1,
    localparam int unsigned DW      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [IN_AW-1:0]       in_addr,
    output logic [W_AW-1:0]        w_addr,
    output logic [N_AW-1:0]        bias_sel,
    input  logic signed [DW-1:0]   bias,
    output logic                   mac_clr,
    output logic                   mac_en,
    input  logic signed [ACCW-1:0] mac_acc,
    output logic                   out_we,
    output logic [N_AW-1:0]        out_addr,
    output logic [DW-1:0]          out_data
);

    localparam int unsigned SUMW = ACCW + 1;
    localparam logic signed [SUMW-1:0] SAT_MAX = SUMW'(127);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [N_AW-1:0]   n_q;
    logic [IN_AW-1:0]  i_q;
    logic              busy_q;
    logic              done_q;
    logic              mac_clr_q;
    logic              mac_en_q;
    logic              out_we_q;
    logic [IN_AW-1:0]  in_addr_q;
    logic [W_AW-1:0]   w_addr_q;
    logic [N_AW-1:0]   bias_sel_q;
    logic [N_AW-1:0]   out_addr_q;

    logic signed [SUMW-1:0] sum_c;
    logic signed [SUMW-1:0] r_c;
    logic [DW-1:0]          act_c;

    // Layer control FSM; every control output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            i_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            out_we_q   <= 1'b0;
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            bias_sel_q <= '0;
            out_addr_q <= '0;
        end else begin
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            out_we_q  <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_CLEAR;
                        busy_q     <= 1'b1;
                        mac_clr_q  <= 1'b1;
                        i_q        <= '0;
                        bias_sel_q <= n_q;
                    end
                end
                S_CLEAR: begin
                    state_q   <= S_MAC;
                    in_addr_q <= i_q;
                    w_addr_q  <= W_AW'(n_q * N_IN);
                end
                S_MAC: begin
                    // Enable trails the issued address by the memory read latency.
                    mac_en_q <= 1'b1;
                    if (i_q == IN_AW'(N_IN - 1)) begin
                        state_q <= S_DRAIN;
                    end else begin
                        i_q       <= i_q + IN_AW'(1);
                        in_addr_q <= i_q + IN_AW'(1);
                        w_addr_q  <= w_addr_q + W_AW'(1);
                    end
                end
                S_DRAIN: begin
                    state_q    <= S_WRITE;
                    out_we_q   <= 1'b1;
                    out_addr_q <= n_q;
                end
                S_WRITE: begin
                    if (n_q == N_AW'(N_NEURON - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_CLEAR;
                        n_q        <= n_q + N_AW'(1);
                        i_q        <= '0;
                        mac_clr_q  <= 1'b1;
                        bias_sel_q <= n_q + N_AW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    n_q     <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bias add, fixed-point rescale, ReLU and clamp to 0..127; the accumulator
    // only holds the final product during WRITE, so this is read straight from it.
    always_comb begin
        sum_c = SUMW'(mac_acc) + (SUMW'(bias) <<< SHIFT);
        r_c   = sum_c >>> SHIFT;
        act_c = '0;
        if (r_c[SUMW-1]) begin
            act_c = '0;
        end else if (r_c > SAT_MAX) begin
            act_c = DW'(127);
        end else begin
            act_c = r_c[DW-1:0];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mac_clr  = mac_clr_q;
    assign mac_en   = mac_en_q;
    assign in_addr  = in_addr_q;
    assign w_addr   = w_addr_q;
    assign bias_sel = bias_sel_q;
    assign out_addr = out_addr_q;
    // A write coinciding with a reset request is suppressed.
    assign out_we   = out_we_q & ~rst;
    assign out_data = out_we ? act_c : '0;

endmodule
